cdb_arbiter: RTL and testbench

- Producer end of the common data bus (CDB) seen by every reservation station entry.
- Collects completed results from the three functional-unit classes (ALU/ex, multiplier, memory) into per-class result queues.
- Broadcasts one result per cycle as cdb_valid/cdb_tag/rob_idx/value, using round-robin arbitration.
- Generates ex_free/mult_free/mem_free back to the reservation stations via per-class credit counters, so a result is never dropped.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_defines.sv | 15 +
 rtl/cdb_fifo.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 153 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// CDB arbiter package: widths, source ids, result payload and rr helper.
`include "cdb_defines.sv"

package cdb_arbiter_pkg;

   localparam int unsigned PRF_W    = `PRF_IDX;
   localparam int unsigned ROB_W    = `ROB_IDX;
   localparam int unsigned VAL_W    = 64;
   localparam int unsigned NSRC     = `CDB_NSRC;
   localparam int unsigned SRC_W    = 2;
   localparam int unsigned SRC_EX   = `CDB_SRC_EX;
   localparam int unsigned SRC_MULT = `CDB_SRC_MULT;
   localparam int unsigned SRC_MEM  = `CDB_SRC_MEM;

   localparam logic [PRF_W-1:0] ZERO_PRF = `ZERO_PRF;

   typedef struct packed {
      logic [PRF_W-1:0] tag;
      logic [ROB_W-1:0] rob;
      logic [VAL_W-1:0] value;
   } cdb_entry_t;

   // Next source in round-robin order, wrapping modulo NSRC.
   function automatic logic [SRC_W-1:0] src_next(input logic [SRC_W-1:0] s);
      return (s >= SRC_W'(NSRC - 1)) ? '0 : s + SRC_W'(1);
   endfunction

endpackage

// File: rtl/cdb_defines.sv
// Shared CDB defines: register/ROB index widths, the zero physical register
// and the source numbering used on the common data bus.
`ifndef CDB_DEFINES_SV
`define CDB_DEFINES_SV

`define PRF_IDX      6
`define ROB_IDX      5
`define ZERO_PRF     6'd0

`define CDB_NSRC     3
`define CDB_SRC_EX   0
`define CDB_SRC_MULT 1
`define CDB_SRC_MEM  2

`endif

// File: rtl/cdb_fifo.sv
// Circular result queue: push at tail, pop at head, head data read combinationally.
module cdb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX   = 2,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic         full_c_o,
   output logic         empty_c_o,
   output logic [W-1:0] head_c_o
);

   localparam int unsigned CNT_W = IDX + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [IDX-1:0]   head_q, head_d;
   logic [IDX-1:0]   tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full_c_o  = (count_q == CNT_W'(DEPTH));
   assign empty_c_o = (count_q == '0);
   assign head_c_o  = mem_q[head_q];

   // Pointer and occupancy next-state; pushes into a full queue are dropped.
   always_comb begin
      do_push = push_i && !full_c_o;
      do_pop  = pop_i && !empty_c_o;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (do_push) tail_d = tail_q + IDX'(1);
      if (do_pop)  head_d = head_q + IDX'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
   end

   // Pointer/count state, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q] <= din_i;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-class result queues, round-robin broadcast, credit-based
// free signals back to the reservation stations.
// Optional macro CDB_BYPASS_EN: an empty-queue result may go straight to the
// CDB in its done cycle when nothing queued wins the grant.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
   parameter int unsigned Q_DEPTH = 4,
   parameter int unsigned Q_IDX   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_issue,
   input  logic             mult_issue,
   input  logic             mem_issue,
   input  logic             ex_done,
   input  logic             mult_done,
   input  logic             mem_done,
   input  logic [PRF_W-1:0] ex_tag,
   input  logic [PRF_W-1:0] mult_tag,
   input  logic [PRF_W-1:0] mem_tag,
   input  logic [ROB_W-1:0] ex_rob,
   input  logic [ROB_W-1:0] mult_rob,
   input  logic [ROB_W-1:0] mem_rob,
   input  logic [63:0]      ex_value,
   input  logic [63:0]      mult_value,
   input  logic [63:0]      mem_value,
   output logic             ex_free,
   output logic             mult_free,
   output logic             mem_free,
   output logic             cdb_valid,
   output logic [PRF_W-1:0] cdb_tag,
   output logic [ROB_W-1:0] cdb_rob_idx,
   output logic [63:0]      cdb_value
);

   localparam int unsigned CNT_W = Q_IDX + 1;

   logic [NSRC-1:0]  issue_c, done_c, q_req_c, q_empty_c, q_full_c;
   logic [NSRC-1:0]  push_c, pop_c, grant_c;
   cdb_entry_t       in_c   [NSRC];
   cdb_entry_t       head_c [NSRC];
   cdb_entry_t       sel_c;
   logic [CNT_W-1:0] credit_q [NSRC];
   logic [CNT_W-1:0] credit_d [NSRC];
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d, gnt_src_c, arb_idx_c;
   logic             gnt_vld_c, gnt_byp_c;

   assign issue_c = {mem_issue, mult_issue, ex_issue};
   assign done_c  = {mem_done, mult_done, ex_done};
   assign in_c[SRC_EX]   = '{tag: ex_tag,   rob: ex_rob,   value: ex_value};
   assign in_c[SRC_MULT] = '{tag: mult_tag, rob: mult_rob, value: mult_value};
   assign in_c[SRC_MEM]  = '{tag: mem_tag,  rob: mem_rob,  value: mem_value};

   for (genvar g = 0; g < NSRC; g++) begin : g_q
      cdb_fifo #(
         .DEPTH (Q_DEPTH),
         .IDX   (Q_IDX),
         .W     ($bits(cdb_entry_t))
      ) u_q (
         .clk       (clk),
         .reset     (reset),
         .push_i    (push_c[g]),
         .din_i     (in_c[g]),
         .pop_i     (pop_c[g]),
         .full_c_o  (q_full_c[g]),
         .empty_c_o (q_empty_c[g]),
         .head_c_o  (head_c[g])
      );
      assign q_req_c[g] = !q_empty_c[g];
   end

`ifdef CDB_BYPASS_EN
   logic [NSRC-1:0] byp_req_c;
   assign byp_req_c = q_empty_c & done_c;
`endif

   // Round-robin pick from rr_ptr; queued heads outrank same-cycle bypass.
   always_comb begin
      gnt_vld_c = 1'b0;
      gnt_byp_c = 1'b0;
      gnt_src_c = '0;
      arb_idx_c = rr_ptr_q;
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (!gnt_vld_c && q_req_c[arb_idx_c]) begin
            gnt_vld_c = 1'b1;
            gnt_src_c = arb_idx_c;
         end
         arb_idx_c = src_next(arb_idx_c);
      end
`ifdef CDB_BYPASS_EN
      arb_idx_c = rr_ptr_q;
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (!gnt_vld_c && byp_req_c[arb_idx_c]) begin
            gnt_vld_c = 1'b1;
            gnt_byp_c = 1'b1;
            gnt_src_c = arb_idx_c;
         end
         arb_idx_c = src_next(arb_idx_c);
      end
`endif
   end

   // Queue control and credit next-state per source.
   always_comb begin
      grant_c  = '0;
      pop_c    = '0;
      push_c   = '0;
      credit_d = credit_q;
      for (int unsigned i = 0; i < NSRC; i++) begin
         grant_c[i] = gnt_vld_c && (gnt_src_c == SRC_W'(i));
         pop_c[i]   = grant_c[i] && !gnt_byp_c;
         push_c[i]  = done_c[i] && !(grant_c[i] && gnt_byp_c) && !q_full_c[i];
         if (issue_c[i] && !grant_c[i]) begin
            credit_d[i] = (credit_q[i] == '0) ? '0 : credit_q[i] - CNT_W'(1);
         end else if (grant_c[i] && !issue_c[i]) begin
            credit_d[i] = credit_q[i] + CNT_W'(1);
         end
      end
   end

   assign rr_ptr_d = gnt_vld_c ? src_next(gnt_src_c) : rr_ptr_q;

   // CDB drive: granted head (or bypassed input), idle values otherwise.
   always_comb begin
      sel_c       = gnt_byp_c ? in_c[gnt_src_c] : head_c[gnt_src_c];
      cdb_valid   = gnt_vld_c;
      cdb_tag     = ZERO_PRF;
      cdb_rob_idx = '0;
      cdb_value   = '0;
      if (gnt_vld_c) begin
         cdb_tag     = sel_c.tag;
         cdb_rob_idx = sel_c.rob;
         cdb_value   = sel_c.value;
      end
   end

   assign ex_free   = (credit_q[SRC_EX]   != '0);
   assign mult_free = (credit_q[SRC_MULT] != '0);
   assign mem_free  = (credit_q[SRC_MEM]  != '0);

   // Credits and rr pointer; reset discards everything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= '0;
         for (int unsigned i = 0; i < NSRC; i++) credit_q[i] <= CNT_W'(Q_DEPTH);
      end else begin
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed results with hand-ordered
// expected broadcasts, plus direct checks of latency, credits and reset.
import cdb_arbiter_pkg::*;

module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             ex_issue, mult_issue, mem_issue;
   logic             ex_done, mult_done, mem_done;
   logic [PRF_W-1:0] ex_tag, mult_tag, mem_tag;
   logic [ROB_W-1:0] ex_rob, mult_rob, mem_rob;
   logic [63:0]      ex_value, mult_value, mem_value;
   logic             ex_free, mult_free, mem_free;
   logic             cdb_valid;
   logic [PRF_W-1:0] cdb_tag;
   logic [ROB_W-1:0] cdb_rob_idx;
   logic [63:0]      cdb_value;

   int         n_vec = 0;
   int         n_err = 0;
   int         viol  = 0;
   bit         sb_en = 1'b0;
   cdb_entry_t exp_q [$];
   cdb_entry_t mon_e;

   cdb_arbiter #(.Q_DEPTH(4), .Q_IDX(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .ex_issue    (ex_issue),
      .mult_issue  (mult_issue),
      .mem_issue   (mem_issue),
      .ex_done     (ex_done),
      .mult_done   (mult_done),
      .mem_done    (mem_done),
      .ex_tag      (ex_tag),
      .mult_tag    (mult_tag),
      .mem_tag     (mem_tag),
      .ex_rob      (ex_rob),
      .mult_rob    (mult_rob),
      .mem_rob     (mem_rob),
      .ex_value    (ex_value),
      .mult_value  (mult_value),
      .mem_value   (mem_value),
      .ex_free     (ex_free),
      .mult_free   (mult_free),
      .mem_free    (mem_free),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_rob_idx (cdb_rob_idx),
      .cdb_value   (cdb_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic clear_in();
      ex_issue = 1'b0; mult_issue = 1'b0; mem_issue = 1'b0;
      ex_done  = 1'b0; mult_done  = 1'b0; mem_done  = 1'b0;
      ex_tag   = '0;   mult_tag   = '0;   mem_tag   = '0;
      ex_rob   = '0;   mult_rob   = '0;   mem_rob   = '0;
      ex_value = '0;   mult_value = '0;   mem_value = '0;
   endtask

   task automatic drive_src(input int s, input logic [PRF_W-1:0] tag,
                            input logic [ROB_W-1:0] rob, input logic [63:0] val,
                            input bit iss);
      case (s)
         0: begin ex_done = 1'b1; ex_issue = iss; ex_tag = tag; ex_rob = rob; ex_value = val; end
         1: begin mult_done = 1'b1; mult_issue = iss; mult_tag = tag; mult_rob = rob; mult_value = val; end
         default: begin mem_done = 1'b1; mem_issue = iss; mem_tag = tag; mem_rob = rob; mem_value = val; end
      endcase
   endtask

   task automatic expect_res(input logic [PRF_W-1:0] tag, input logic [ROB_W-1:0] rob,
                             input logic [63:0] val);
      cdb_entry_t e;
      e.tag = tag; e.rob = rob; e.value = val;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Wait (bounded) for every expected broadcast to appear.
   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || cdb_valid) && n < 30) begin
         tick();
         n++;
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d results still pending after %0d cycles, expected 0",
                  exp_q.size(), n);
      end
      tick();
   endtask

   // Monitor: every broadcast must match the next expected result, idle fields otherwise.
   always @(negedge clk) begin
      if (!reset && sb_en) begin
         if (cdb_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_unexpected: got tag %0d rob %0d value %0h, expected no broadcast",
                        cdb_tag, cdb_rob_idx, cdb_value);
            end else begin
               mon_e = exp_q.pop_front();
               check("sb_tag",   64'(cdb_tag),     64'(mon_e.tag));
               check("sb_rob",   64'(cdb_rob_idx), 64'(mon_e.rob));
               check("sb_value", cdb_value,        mon_e.value);
            end
         end else begin
            check("idle_tag",   64'(cdb_tag),     64'(ZERO_PRF));
            check("idle_rob",   64'(cdb_rob_idx), 64'd0);
            check("idle_value", cdb_value,        64'd0);
         end
      end
   end

   // Protocol watch: dispatch into a class with no credit.
   always @(posedge clk) begin
      if (!reset) begin
         if ((ex_issue && !ex_free) || (mult_issue && !mult_free) || (mem_issue && !mem_free))
            viol++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear_in();
      settle();
      // Reset state
      check("rst_valid",     64'(cdb_valid),   64'd0);
      check("rst_tag",       64'(cdb_tag),     64'(ZERO_PRF));
      check("rst_value",     cdb_value,        64'd0);
      check("rst_ex_free",   64'(ex_free),     64'd1);
      check("rst_mult_free", 64'(mult_free),   64'd1);
      check("rst_mem_free",  64'(mem_free),    64'd1);
      tick(); tick();
      reset = 1'b0;
      sb_en = 1'b1;
      tick();
      check("post_rst_valid", 64'(cdb_valid), 64'd0);

      // Single ex result: latency 1 (0 with bypass), visible for one cycle only
      drive_src(0, 6'd12, 5'd5, 64'hDEAD, 1'b1);
      expect_res(6'd12, 5'd5, 64'hDEAD);
      settle();
      check("single_n_valid", 64'(cdb_valid), 64'(BYP));
      tick();
      clear_in();
      settle();
      check("single_n1_valid", 64'(cdb_valid), 64'(!BYP));
      tick();
      check("single_n2_valid", 64'(cdb_valid), 64'd0);
      drain();

      // Three-way tie from rr_ptr=0: ex, mult, mem (mem carries the zero tag)
      do_reset();
      drive_src(0, 6'd1, 5'd1, 64'h100, 1'b1);
      drive_src(1, 6'd2, 5'd2, 64'h200, 1'b1);
      drive_src(2, ZERO_PRF, 5'd3, 64'h300, 1'b1);
      expect_res(6'd1, 5'd1, 64'h100);
      expect_res(6'd2, 5'd2, 64'h200);
      expect_res(ZERO_PRF, 5'd3, 64'h300);
      tick();
      clear_in();
      drain();
      // One ex grant moves rr_ptr to 1, then the tie resolves mult, mem, ex
      drive_src(0, 6'd4, 5'd4, 64'h400, 1'b1);
      expect_res(6'd4, 5'd4, 64'h400);
      tick();
      clear_in();
      drain();
      drive_src(0, 6'd5, 5'd5, 64'h500, 1'b1);
      drive_src(1, 6'd6, 5'd6, 64'h600, 1'b1);
      drive_src(2, 6'd7, 5'd7, 64'h700, 1'b1);
      expect_res(6'd6, 5'd6, 64'h600);
      expect_res(6'd7, 5'd7, 64'h700);
      expect_res(6'd5, 5'd5, 64'h500);
      tick();
      clear_in();
      drain();

      // Mult credits: four issues exhaust, fifth is a violation, one grant returns
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         mult_issue = 1'b1;
         tick();
         mult_issue = 1'b0;
         settle();
         check($sformatf("mult_free_after_%0d", i), 64'(mult_free), (i < 4) ? 64'd1 : 64'd0);
      end
      mult_issue = 1'b1;
      tick();
      mult_issue = 1'b0;
      settle();
      check("mult_violation_seen", 64'(viol),      64'd1);
      check("mult_credit_sat",     64'(mult_free), 64'd0);
      drive_src(1, 6'd9, 5'd9, 64'h9999, 1'b0);
      expect_res(6'd9, 5'd9, 64'h9999);
      tick();
      clear_in();
      settle();
      check("mult_free_grant_cycle", 64'(mult_free), 64'(BYP));
      tick();
      check("mult_free_after_grant", 64'(mult_free), 64'd1);
      drain();

      // Asynchronous reset with results queued
      do_reset();
      sb_en = 1'b0;
      mult_issue = 1'b1;
      repeat (4) tick();
      mult_issue = 1'b0;
      settle();
      check("pre_rst_mult_free", 64'(mult_free), 64'd0);
      drive_src(0, 6'd40, 5'd10, 64'hA0, 1'b0);
      drive_src(1, 6'd41, 5'd11, 64'hA1, 1'b0);
      drive_src(2, 6'd42, 5'd12, 64'hA2, 1'b0);
      tick();
      clear_in();
      settle();
      check("pre_rst_valid", 64'(cdb_valid), 64'd1);
      #2;
      reset = 1'b1;
      settle();
      check("async_rst_valid",     64'(cdb_valid),   64'd0);
      check("async_rst_tag",       64'(cdb_tag),     64'(ZERO_PRF));
      check("async_rst_rob",       64'(cdb_rob_idx), 64'd0);
      check("async_rst_value",     cdb_value,        64'd0);
      check("async_rst_ex_free",   64'(ex_free),     64'd1);
      check("async_rst_mult_free", 64'(mult_free),   64'd1);
      check("async_rst_mem_free",  64'(mem_free),    64'd1);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("flushed_valid_%0d", i), 64'(cdb_valid), 64'd0);
      end
      sb_en = 1'b1;

      // Ex credit 1 with same-cycle issue and grant: stays 1, then one issue empties it
      do_reset();
      ex_issue = 1'b1;
      repeat (3) tick();
      ex_issue = 1'b0;
      settle();
      check("ex_free_credit1", 64'(ex_free), 64'd1);
      expect_res(6'd20, 5'd20, 64'h2020);
      if (BYP) begin
         drive_src(0, 6'd20, 5'd20, 64'h2020, 1'b1);
         tick();
         clear_in();
      end else begin
         drive_src(0, 6'd20, 5'd20, 64'h2020, 1'b0);
         tick();
         clear_in();
         ex_issue = 1'b1;
         tick();
         ex_issue = 1'b0;
      end
      settle();
      check("ex_free_issue_and_grant", 64'(ex_free), 64'd1);
      ex_issue = 1'b1;
      tick();
      ex_issue = 1'b0;
      settle();
      check("ex_free_credit0", 64'(ex_free), 64'd0);
      drain();

      // Wrap: ten ex results with two mult results interleaved early
      do_reset();
      expect_res(6'd1, 5'd1, 64'hE001);
      expect_res(6'd33, 5'd17, 64'hF001);
      expect_res(6'd2, 5'd2, 64'hE002);
      expect_res(6'd34, 5'd18, 64'hF002);
      for (int k = 3; k <= 10; k++) expect_res(PRF_W'(k), ROB_W'(k), 64'hE000 + 64'(k));
      for (int k = 1; k <= 10; k++) begin
         drive_src(0, PRF_W'(k), ROB_W'(k), 64'hE000 + 64'(k), 1'b1);
         if (k <= 2) drive_src(1, PRF_W'(32 + k), ROB_W'(16 + k), 64'hF000 + 64'(k), 1'b1);
         tick();
         clear_in();
      end
      drain();
      check("wrap_ex_free", 64'(ex_free), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
